// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline issue controller.
//               Define FORWARDING_EN to select bypass-network latencies.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int SB_CNT_W = 2;

  typedef enum logic {
    WR_CLASS_ALU  = 1'b0,
    WR_CLASS_LOAD = 1'b1
  } wr_class_e;

`ifdef FORWARDING_EN
  // Bypass paths hide ALU latency entirely; a load still costs one slot.
  localparam logic [SB_CNT_W-1:0] LAT_ALU  = 2'd0;
  localparam logic [SB_CNT_W-1:0] LAT_LOAD = 2'd1;
`else
  // Only the register file (write first half, read second half) carries data.
  localparam logic [SB_CNT_W-1:0] LAT_ALU  = 2'd2;
  localparam logic [SB_CNT_W-1:0] LAT_LOAD = 2'd2;
`endif

  // Scoreboard reload value for a given write class.
  function automatic logic [SB_CNT_W-1:0] lat_of(input logic cls);
    return (cls == WR_CLASS_LOAD) ? LAT_LOAD : LAT_ALU;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_entry.sv
//==============================================================================
// Module      : sb_entry
// Description : One scoreboard down-counter for a single architectural
//               register. A set overrides the decrement; hold freezes it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sb_entry
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                set,
  input  logic [SB_CNT_W-1:0] set_val,
  output logic [SB_CNT_W-1:0] cnt
);

  logic [SB_CNT_W-1:0] r_cnt;

  // Reload on a new in-flight write, otherwise count down toward zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!hold) begin
      if (set) begin
        r_cnt <= set_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - SB_CNT_W'(1);
      end
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_ctrl.sv
//==============================================================================
// Module      : hazard_scoreboard_ctrl
// Description : ID-stage issue controller for a 5-stage MIPS pipeline. Keeps a
//               per-GPR scoreboard of in-flight writes, decides issue/stall,
//               inserts bubbles into EX and counts hazard-stall cycles.
//               Build option: FORWARDING_EN (bypass latencies, see package).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  input  logic             wr_en_i,
  input  logic [REG_W-1:0] wr_reg_i,
  input  logic             wr_class_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic             bubble_o,
  output logic [NREGS-1:0] busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [SB_CNT_W-1:0] w_cnt [NREGS];
  logic [SB_CNT_W-1:0] w_lat;
  logic                w_rs_busy;
  logic                w_rt_busy;
  logic                w_haz;
  logic                w_stall;
  logic                w_issue;
  logic                w_bubble;
  logic [CNT_W-1:0]    r_stall_cnt;

  // r0 is hardwired: never tracked, never busy.
  assign w_cnt[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_sb
      logic w_set;
      // Only an instruction actually entering EX claims its destination.
      assign w_set = w_issue & wr_en_i & (wr_reg_i == REG_W'(gi)) & (w_lat != '0);

      sb_entry u_entry (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold_i),
        .set     (w_set),
        .set_val (w_lat),
        .cnt     (w_cnt[gi])
      );
    end
  endgenerate

  // Hazard check uses registered counters only, so the ID instruction's own
  // write can never stall itself.
  always_comb begin
    w_lat     = lat_of(wr_class_i);
    w_rs_busy = use_rs_i & (w_cnt[rs_i] != '0);
    w_rt_busy = use_rt_i & (w_cnt[rt_i] != '0);
    w_haz     = id_valid_i & (w_rs_busy | w_rt_busy);
    w_stall   = w_haz & ~flush_i;
    w_issue   = id_valid_i & ~w_haz & ~flush_i & ~hold_i;
    w_bubble  = ~hold_i & ~w_issue;
  end

  // Control outputs are forced low for as long as reset is asserted.
  always_comb begin
    issue_o  = reset & w_issue;
    stall_o  = reset & w_stall;
    bubble_o = reset & w_bubble;
    busy_o   = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_o[r] = reset & (w_cnt[r] != '0);
    end
  end

  // Saturating count of hazard-stall cycles; frozen cycles are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall & ~hold_i & (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
//==============================================================================
// Module      : tb_hazard_scoreboard_ctrl
// Description : Directed self-checking bench for hazard_scoreboard_ctrl.
//               Expected stall counts follow the FORWARDING_EN build option.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_scoreboard_ctrl;

`ifdef FORWARDING_EN
  localparam int ALU_STALLS  = 0;
  localparam int LOAD_STALLS = 1;
`else
  localparam int ALU_STALLS  = 2;
  localparam int LOAD_STALLS = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid_i;
  logic [4:0]  rs_i, rt_i, wr_reg_i;
  logic        use_rs_i, use_rt_i, wr_en_i, wr_class_i;
  logic        flush_i, hold_i;
  logic        issue_o, stall_o, bubble_o;
  logic [31:0] busy_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  hazard_scoreboard_ctrl #(.CNT_W(32), .NREGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid_i  (id_valid_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .use_rs_i    (use_rs_i),
    .use_rt_i    (use_rt_i),
    .wr_en_i     (wr_en_i),
    .wr_reg_i    (wr_reg_i),
    .wr_class_i  (wr_class_i),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .issue_o     (issue_o),
    .stall_o     (stall_o),
    .bubble_o    (bubble_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic wen,
                       input logic [4:0] wreg, input logic cls);
    id_valid_i = v;   rs_i = rs;   use_rs_i = urs; rt_i = rt; use_rt_i = urt;
    wr_en_i    = wen; wr_reg_i = wreg; wr_class_i = cls;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    end
  endtask

  // Producer writes dst, next instruction reads dst via rs; expect n stalls.
  task automatic dep_test(input string tag, input logic cls, input logic [4:0] dst, input int n);
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, dst, cls);
    #1 chk({tag, "_prod_issue"}, 32'(issue_o), 32'd1);
    @(negedge clk);
    drive(1'b1, dst, 1'b1, 5'd7, 1'b1, 1'b1, 5'd6, 1'b0);
    #1 chk({tag, "_busy_dst"}, 32'(busy_o[dst]), 32'(n != 0));
    for (int k = 0; k < n; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk({tag, "_stall"},  32'(stall_o),  32'd1);
      chk({tag, "_bubble"}, 32'(bubble_o), 32'd1);
      chk({tag, "_noissue"}, 32'(issue_o), 32'd0);
    end
    if (n != 0) @(negedge clk);
    #1;
    chk({tag, "_issue"},   32'(issue_o),  32'd1);
    chk({tag, "_nostall"}, 32'(stall_o),  32'd0);
    chk({tag, "_nobub"},   32'(bubble_o), 32'd0);
    exp_sc += n;
    idle_cycles(3);
    #1 chk({tag, "_stall_cnt"}, stall_cnt_o, 32'(exp_sc));
  endtask

  initial begin
    reset = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd5, 1'b0);

    // Reset state: outputs forced low even with a ready instruction in ID.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_issue",  32'(issue_o),  32'd0);
    chk("rst_stall",  32'(stall_o),  32'd0);
    chk("rst_bubble", 32'(bubble_o), 32'd0);
    chk("rst_busy",   busy_o,        32'd0);
    chk("rst_scnt",   stall_cnt_o,   32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1 chk("idle_bubble", 32'(bubble_o), 32'd1);

    // ALU producer -> dependent reader; load producer -> dependent reader.
    dep_test("alu_dep",  1'b0, 5'd3, ALU_STALLS);
    dep_test("load_dep", 1'b1, 5'd2, LOAD_STALLS);
    // Writes to r0 are never tracked.
    dep_test("r0_alu",   1'b0, 5'd0, 0);
    dep_test("r0_load",  1'b1, 5'd0, 0);

    // Hold during a hazard: nothing moves, no bubble, counter frozen.
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd3, 1'b1);
    #1 chk("hold_prod_issue", 32'(issue_o), 32'd1);
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall",  32'(stall_o),   32'd1);
      chk("hold_bubble", 32'(bubble_o),  32'd0);
      chk("hold_issue",  32'(issue_o),   32'd0);
      chk("hold_busy3",  32'(busy_o[3]), 32'd1);
      chk("hold_scnt",   stall_cnt_o,    32'(exp_sc));
      @(negedge clk);
    end
    hold_i = 1'b0;
    for (int k = 0; k < LOAD_STALLS; k++) begin
      if (k != 0) @(negedge clk);
      #1 chk("rel_stall", 32'(stall_o), 32'd1);
    end
    @(negedge clk);
    #1 chk("rel_issue", 32'(issue_o), 32'd1);
    exp_sc += LOAD_STALLS;
    idle_cycles(3);
    #1 chk("rel_scnt", stall_cnt_o, 32'(exp_sc));

    // Flush kills a dependent lw r9 in ID; older r3 keeps counting.
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd3, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("flush_issue",  32'(issue_o),  32'd0);
    chk("flush_stall",  32'(stall_o),  32'd0);
    chk("flush_bubble", 32'(bubble_o), 32'd1);
    chk("flush_busy3",  32'(busy_o[3]), 32'd1);
    // Flush together with hold: hold wins, no bubble.
    hold_i = 1'b1;
    #1 chk("flushhold_bubble", 32'(bubble_o), 32'd0);
    hold_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("flush_busy9", 32'(busy_o[9]), 32'd0);
    chk("flush_busy3_dec", 32'(busy_o[3]), 32'(LOAD_STALLS > 1));
    @(negedge clk);
    #1;
    chk("flush_busy3_done", 32'(busy_o[3]), 32'd0);
    chk("flush_scnt", stall_cnt_o, 32'(exp_sc));

    // Reset asserted in the middle of a stall on r5.
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    #1 chk("mid_stall", 32'(stall_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_issue",  32'(issue_o),  32'd0);
    chk("mid_rst_stall",  32'(stall_o),  32'd0);
    chk("mid_rst_bubble", 32'(bubble_o), 32'd0);
    chk("mid_rst_busy",   busy_o,        32'd0);
    chk("mid_rst_scnt",   stall_cnt_o,   32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_issue", 32'(issue_o), 32'd1);
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    #1 chk("post_rst_scnt", stall_cnt_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
